// File: rtl/axis_peak_finder.sv
// Multi-channel windowed peak detector on a tlast-framed AXI-Stream sample feed.
// Optional feature macro: PEAK_INDEX_EN (per-channel frame index of each peak).
module axis_peak_finder #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned SAMPLE_WIDTH         = 16,
  parameter int unsigned BEATS_PER_FRAME      = 2,
  parameter int unsigned WINDOW_FRAMES        = 1024,
  parameter bit          SIGNED_SAMPLES       = 1'b1
) (
  input  logic                                                                   s_axis_aclk,
  input  logic                                                                   s_axis_aresetn,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]                                        s_axis_tdata,
  input  logic                                                                   s_axis_tvalid,
  output logic                                                                   s_axis_tready,
  input  logic                                                                   s_axis_tlast,
  output logic [(C_S_AXIS_TDATA_WIDTH/SAMPLE_WIDTH)*BEATS_PER_FRAME*SAMPLE_WIDTH-1:0] peak_data,
  output logic [(C_S_AXIS_TDATA_WIDTH/SAMPLE_WIDTH)*BEATS_PER_FRAME*$clog2(WINDOW_FRAMES)-1:0] peak_index,
  output logic                                                                   peak_valid,
  input  logic                                                                   peak_ready,
  output logic                                                                   overrun_err,
  output logic                                                                   framing_err,
  input  logic                                                                   err_clear
);
  localparam int unsigned LANES  = C_S_AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
  localparam int unsigned NUM_CH = LANES * BEATS_PER_FRAME;
  localparam int unsigned IDX_W  = $clog2(WINDOW_FRAMES);
  localparam int unsigned BEAT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam logic [SAMPLE_WIDTH-1:0] ACC_MIN =
    SIGNED_SAMPLES ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}} : {SAMPLE_WIDTH{1'b0}};

  if (WINDOW_FRAMES < 2) begin : g_bad_window
    $error("axis_peak_finder: WINDOW_FRAMES must be >= 2");
  end
  if ((C_S_AXIS_TDATA_WIDTH % SAMPLE_WIDTH) != 0) begin : g_bad_width
    $error("axis_peak_finder: TDATA width must be a multiple of SAMPLE_WIDTH");
  end

  function automatic logic greater(input logic [SAMPLE_WIDTH-1:0] a,
                                   input logic [SAMPLE_WIDTH-1:0] b);
    if (SIGNED_SAMPLES) return $signed(a) > $signed(b);
    else                return a > b;
  endfunction

  logic                              tready_q;
  logic [BEAT_W-1:0]                 beat_q, beat_d;
  logic [IDX_W-1:0]                  frame_q, frame_d;
  logic [SAMPLE_WIDTH-1:0]           acc_q [NUM_CH];
  logic [SAMPLE_WIDTH-1:0]           acc_d [NUM_CH];
  logic [SAMPLE_WIDTH-1:0]           acc_max [NUM_CH];
  logic [NUM_CH*SAMPLE_WIDTH-1:0]    peak_data_q, peak_data_d;
  logic                              peak_valid_q, peak_valid_d;
  logic                              overrun_q, overrun_d;
  logic                              framing_q, framing_d;
  logic                              accept, last_beat, frame_done, close_win;
  logic [NUM_CH-1:0]                 upd;
  logic [SAMPLE_WIDTH-1:0]           sample;

  always_comb begin
    accept     = s_axis_tvalid & tready_q;
    last_beat  = (beat_q == BEAT_W'(BEATS_PER_FRAME - 1));
    frame_done = accept & (s_axis_tlast | last_beat);
    close_win  = frame_done & (frame_q == IDX_W'(WINDOW_FRAMES - 1));

    beat_d = beat_q;
    if (accept) beat_d = frame_done ? '0 : beat_q + BEAT_W'(1);
    frame_d = frame_q;
    if (frame_done) frame_d = close_win ? '0 : frame_q + IDX_W'(1);

    // acc_max is the running max including the current beat, so the close
    // beat's samples land in the published result while acc restarts.
    sample      = '0;
    upd         = '0;
    peak_data_d = peak_data_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sample     = s_axis_tdata[(c % LANES)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      upd[c]     = accept && (beat_q == BEAT_W'(c / LANES)) && greater(sample, acc_q[c]);
      acc_max[c] = upd[c] ? sample : acc_q[c];
      acc_d[c]   = close_win ? ACC_MIN : acc_max[c];
      if (close_win) peak_data_d[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = acc_max[c];
    end

    peak_valid_d = close_win | (peak_valid_q & ~peak_ready);
    overrun_d    = (close_win & peak_valid_q & ~peak_ready) | (overrun_q & ~err_clear);
    framing_d    = (accept & (s_axis_tlast ^ last_beat)) | (framing_q & ~err_clear);
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      tready_q     <= 1'b0;
      beat_q       <= '0;
      frame_q      <= '0;
      peak_data_q  <= '0;
      peak_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) acc_q[c] <= ACC_MIN;
    end else begin
      tready_q     <= 1'b1;
      beat_q       <= beat_d;
      frame_q      <= frame_d;
      peak_data_q  <= peak_data_d;
      peak_valid_q <= peak_valid_d;
      overrun_q    <= overrun_d;
      framing_q    <= framing_d;
      acc_q        <= acc_d;
    end
  end

`ifdef PEAK_INDEX_EN
  logic [IDX_W-1:0]        idx_q [NUM_CH];
  logic [IDX_W-1:0]        idx_d [NUM_CH];
  logic [NUM_CH*IDX_W-1:0] peak_index_q, peak_index_d;

  always_comb begin
    peak_index_d = peak_index_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      idx_d[c] = upd[c] ? frame_q : idx_q[c];
      if (close_win) begin
        peak_index_d[c*IDX_W +: IDX_W] = idx_d[c];
        idx_d[c] = '0;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      peak_index_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) idx_q[c] <= '0;
    end else begin
      peak_index_q <= peak_index_d;
      idx_q        <= idx_d;
    end
  end

  assign peak_index = peak_index_q;
`else
  assign peak_index = '0;
`endif

  assign s_axis_tready = tready_q;
  assign peak_data     = peak_data_q;
  assign peak_valid    = peak_valid_q;
  assign overrun_err   = overrun_q;
  assign framing_err   = framing_q;

endmodule
